// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the single-port RAM arbiter.
//   req_id_t : identifies a requester (instruction fetch or load/store)
//   STAT_W   : width of the optional grant/conflict statistics counters
package ram_arb_pkg;

    typedef enum logic {REQ_IF, REQ_LS} req_id_t;

    localparam int STAT_W = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: shares one single-port synchronous RAM (registered output,
// read latency 1) between instruction fetch (IF) and load/store (LS).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        IF read request; if_gnt combinational accept
//   if_rvalid/if_rdata    IF read return, one cycle after grant
//   ls_req/ls_we/ls_addr/ls_wdata  LS read/write request; ls_gnt accept
//   ls_rvalid/ls_rdata    LS read return, one cycle after grant
//   ram_addr/ram_data_in/ram_wren/ram_rden  RAM drive
//   ram_data_out          RAM read data (valid the cycle after ram_rden)
//
// Optional build macro RAM_ARB_STATS_EN adds stat_clr input and saturating
// counters stat_if_grants, stat_ls_grants, stat_conflicts.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_if_grants,
    output logic [STAT_W-1:0] stat_ls_grants,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);

    req_id_t last_win;
    req_id_t rd_owner;
    logic    rd_pend;
    logic    conflict;

    assign conflict = if_req & ls_req;

    // LS wins when alone, or on a conflict when IF took the previous one.
    // Grants are masked while reset is held.
    assign ls_gnt = rst_n & ls_req & (~if_req | (last_win == REQ_IF));
    assign if_gnt = rst_n & if_req & ~ls_gnt;

    assign ram_addr    = ls_gnt ? ls_addr : (if_gnt ? if_addr : '0);
    assign ram_data_in = ls_wdata;
    assign ram_wren    = ls_gnt & ls_we;
    assign ram_rden    = if_gnt | (ls_gnt & ~ls_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= REQ_IF;
            rd_pend  <= 1'b0;
            rd_owner <= REQ_IF;
        end else begin
            if (conflict)
                last_win <= ls_gnt ? REQ_LS : REQ_IF;
            rd_pend <= ram_rden;
            if (ram_rden)
                rd_owner <= ls_gnt ? REQ_LS : REQ_IF;
        end
    end

    // RAM output register already provides the one-cycle latency, so the
    // return is steered combinationally from the pending-read tag.
    assign if_rvalid = rd_pend & (rd_owner == REQ_IF);
    assign ls_rvalid = rd_pend & (rd_owner == REQ_LS);
    assign if_rdata  = if_rvalid ? ram_data_out : '0;
    assign ls_rdata  = ls_rvalid ? ram_data_out : '0;

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_grants <= '0;
            stat_ls_grants <= '0;
            stat_conflicts <= '0;
        end else if (stat_clr) begin
            stat_if_grants <= '0;
            stat_ls_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (if_gnt)   stat_if_grants <= sat_inc(stat_if_grants);
            if (ls_gnt)   stat_ls_grants <= sat_inc(stat_ls_grants);
            if (conflict) stat_conflicts <= sat_inc(stat_conflicts);
        end
    end
`endif

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb_ram_sp_arbiter: directed self-checking bench for ram_sp_arbiter, with a
// behavioural registered-output single-port RAM standing in for the parent.
module tb_ram_sp_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req, ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt, ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in, ram_data_out;
    logic              ram_wren, ram_rden;
`ifdef RAM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_if_grants, stat_ls_grants, stat_conflicts;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_sp_arbiter #(.DATA_W(DATA_W), .NUM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_data_out(ram_data_out)
`ifdef RAM_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_if_grants(stat_if_grants),
        .stat_ls_grants(stat_ls_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    // Registered-output single-port RAM.
    logic [DATA_W-1:0] mem [0:1023];
    always_ff @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data_in;
        if (ram_rden) ram_data_out <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ifr, input logic [ADDR_W-1:0] ifa,
                         input logic lsr, input logic we,
                         input logic [ADDR_W-1:0] lsa, input logic [DATA_W-1:0] wd);
        if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_we = we; ls_addr = lsa; ls_wdata = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
`ifdef RAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        rst_n = 1'b0;
        // Requests asserted during reset must not be granted.
        drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0);
        tick();
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
        chk("rst_rden", {31'b0, ram_rden}, 32'd0);
        chk("rst_addr", {22'b0, ram_addr}, 32'd0);
        chk("rst_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // Preload mem[0..3] = A0..A3 through LS writes.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, i[ADDR_W-1:0], 32'hA0 + i);
            chk("wr_gnt", {31'b0, ls_gnt}, 32'd1);
            chk("wr_wren", {31'b0, ram_wren}, 32'd1);
            chk("wr_rden", {31'b0, ram_rden}, 32'd0);
            chk("wr_addr", {22'b0, ram_addr}, i);
            tick();
            chk("wr_no_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
        end
        idle();
        chk("idle_wren", {31'b0, ram_wren}, 32'd0);

        // Write then read of addr 5.
        drive(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
        chk("wr5_wren", {31'b0, ram_wren}, 32'd1);
        chk("wr5_data", ram_data_in, 32'hDEADBEEF);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 10'd5, '0);
        chk("rd5_no_rvalid_for_write", {31'b0, ls_rvalid}, 32'd0);
        chk("rd5_rden", {31'b0, ram_rden}, 32'd1);
        tick();
        idle();
        chk("rd5_rvalid", {31'b0, ls_rvalid}, 32'd1);
        chk("rd5_rdata", ls_rdata, 32'hDEADBEEF);
        chk("rd5_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        tick();
        chk("rd5_rvalid_pulse", {31'b0, ls_rvalid}, 32'd0);

        // IF-only burst, addresses 0..3, sustained one read per cycle.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, i[ADDR_W-1:0], 1'b0, 1'b0, '0, '0);
            else       idle();
            if (i < 4) chk("ifb_gnt", {31'b0, if_gnt}, 32'd1);
            if (i > 0) begin
                chk("ifb_rvalid", {31'b0, if_rvalid}, 32'd1);
                chk("ifb_rdata", if_rdata, 32'hA0 + i - 1);
            end
            chk("ifb_ls_idle", {ls_gnt, ls_rvalid, 30'b0} | ls_rdata, 32'd0);
            tick();
        end
        chk("ifb_end", {31'b0, if_rvalid}, 32'd0);

        // Conflict: IF addr 0, LS read addr 1. Grants LS, IF, LS.
        drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0);
        chk("c1_ls_gnt", {if_gnt, ls_gnt}, 32'd1);
        tick();
        #1;
        chk("c2_if_gnt", {if_gnt, ls_gnt}, 32'd2);
        chk("c2_ls_rv", {if_rvalid, ls_rvalid}, 32'd1);
        chk("c2_ls_rdata", ls_rdata, 32'hA1);
        chk("c2_if_rdata", if_rdata, 32'd0);
        tick();
        #1;
        chk("c3_ls_gnt", {if_gnt, ls_gnt}, 32'd1);
        chk("c3_if_rv", {if_rvalid, ls_rvalid}, 32'd2);
        chk("c3_if_rdata", if_rdata, 32'hA0);
        chk("c3_ls_rdata", ls_rdata, 32'd0);
        tick();
        idle();
        chk("c4_ls_rv", {if_rvalid, ls_rvalid}, 32'd1);
        chk("c4_ls_rdata", ls_rdata, 32'hA1);
        tick();

        // Reset mid-read: last_win is LS now, IF read addr 2 granted then reset.
        drive(1'b1, 10'd2, 1'b0, 1'b0, '0, '0);
        chk("mr_if_gnt", {31'b0, if_gnt}, 32'd1);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid_in_rst", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_rvalid_after", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
        tick();
        chk("mr_rvalid_after2", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
        // last_win back to IF: LS must win this conflict.
        drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd3, '0);
        chk("mr_lastwin_ls", {if_gnt, ls_gnt}, 32'd1);
        tick();
        idle();
        chk("mr_ls_rdata", ls_rdata, 32'hA3);
        tick();

        // Withdrawn request: no grant, no rvalid.
        idle();
        chk("nogrant", {ram_wren, ram_rden, if_gnt, ls_gnt}, 32'd0);

        // Interleaved ownership: IF addr 1, then LS addr 2.
        drive(1'b1, 10'd1, 1'b0, 1'b0, '0, '0);
        chk("il_if_gnt", {if_gnt, ls_gnt}, 32'd2);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 10'd2, '0);
        chk("il_ls_gnt", {if_gnt, ls_gnt}, 32'd1);
        chk("il_if_rv", {if_rvalid, ls_rvalid}, 32'd2);
        chk("il_if_rdata", if_rdata, 32'hA1);
        chk("il_ls_rdata0", ls_rdata, 32'd0);
        tick();
        idle();
        chk("il_ls_rv", {if_rvalid, ls_rvalid}, 32'd1);
        chk("il_ls_rdata", ls_rdata, 32'hA2);
        chk("il_if_rdata0", if_rdata, 32'd0);
        tick();

`ifdef RAM_ARB_STATS_EN
        stat_clr = 1'b1;
        drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0);
        tick();
        stat_clr = 1'b0;
        chk("st_clr_drop", stat_conflicts, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        idle();
        chk("st_conflicts3", stat_conflicts, 32'd3);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("st_conflicts0", stat_conflicts, 32'd0);
        chk("st_if0", stat_if_grants, 32'd0);
        drive(1'b1, 10'd0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 65540; i++) tick();
        idle();
        chk("st_if_sat", stat_if_grants, 32'hFFFF);
        chk("st_ls_none", stat_ls_grants, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: instruction fetch (IF) and load/store (LS).
- Grants at most one RAM access per cycle and drives the RAM port.
- Tracks which requester owns each in-flight read and routes read data back to it.
- Sits between the pipeline front/memory stages and the unified RAM instance, which the parent instantiates.
- The RAM is configured with registered output: read data appears the cycle after the read is issued.

Parameters:
- DATA_W, 32, word width.
- NUM_WORDS, 1024, RAM depth.
- ADDR_W, $clog2(NUM_WORDS), address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_W  IF read data.
- ls_req  in  1  LS request; held until granted.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  LS word address.
- ls_wdata  in  DATA_W  LS write data.
- ls_gnt  out  1  LS request accepted this cycle (combinational).
- ls_rvalid  out  1  LS read data valid.
- ls_rdata  out  DATA_W  LS read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rden  out  1  RAM read enable.
- ram_data_out  in  DATA_W  RAM read data, one cycle after ram_rden.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on rst_n; every register is cleared on assertion.
- Reset values:
  - last_win = IF, so LS wins the first conflict.
  - rd_pend = 0, rd_owner = IF.
  - if_rvalid = ls_rvalid = 0.
  - if_gnt = ls_gnt = 0 while in reset.
- Arbitration (combinational, same cycle):
  - Only one requester asserted: that requester is granted.
  - Both asserted: the requester that did not win the previous conflict is granted (round-robin pointer last_win).
  - last_win updates only on conflict cycles.
  - Exactly one of if_gnt/ls_gnt is high per cycle, or neither if there are no requests.
- RAM drive:
  - ram_addr = granted requester's address; ram_data_in = ls_wdata.
  - ram_wren = ls_gnt & ls_we.
  - ram_rden = if_gnt | (ls_gnt & ~ls_we).
  - With no grant: ram_wren = ram_rden = 0, ram_addr holds 0.
- Read return:
  - On a read grant, register rd_pend = 1 and rd_owner = granting requester.
  - Next cycle: rvalid of the owner is high for exactly one cycle, and its rdata = ram_data_out.
  - rdata of the non-owner holds 0.
  - A grant issued in the same cycle as a return is legal: fully pipelined, one read per cycle sustained, latency exactly 1.
- Writes:
  - Complete at the grant edge; no rvalid is generated.
  - Read of the same address in the following cycle returns the new data.
- Requesters must hold req/addr/we/wdata stable until their gnt is seen; deassertion without a grant is legal (request withdrawn).
- Reset mid-operation: a pending read is discarded and no rvalid follows the reset release.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_if_grants[15:0], stat_ls_grants[15:0], stat_conflicts[15:0].
  - Each counter increments on its event and saturates at 16'hFFFF.
  - All counters clear on reset.
  - Input stat_clr (1 bit) synchronously clears all three; an event in the same cycle as stat_clr is dropped.
- Undefined: no ports and no counter logic.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum logic {REQ_IF, REQ_LS} req_id_t.
  - localparam STAT_W = 16.
- No sub-module is needed. The arbiter is flat; the parent wires it to the ram_sp instance (REGISTERED_OUTPUT = 1).

Test Plan:
- IF-only burst:
  - Stimulus: if_req held 4 cycles, addresses 0..3, RAM preloaded with mem[i] = 32'hA0+i.
  - Response: if_gnt high each cycle; if_rvalid high cycles 2..5 with data A0..A3; ls outputs idle.
- Conflict round-robin:
  - Stimulus: if_req and ls_req (read) both held from reset.
  - Response: grants alternate LS, IF, LS, IF; each rvalid goes to the matching owner one cycle after its grant.
- Write then read:
  - Stimulus: LS write addr 5, data 32'hDEADBEEF; next cycle LS read addr 5.
  - Response: ram_wren pulse, no rvalid for the write; ls_rdata = 32'hDEADBEEF one cycle after the read grant.
- Interleaved ownership:
  - Stimulus: IF read addr 1 granted, next cycle LS read addr 2.
  - Response: if_rvalid then ls_rvalid in consecutive cycles; values never swapped.
- Reset mid-read:
  - Stimulus: rst_n asserted low the cycle after an IF read grant.
  - Response: if_rvalid stays 0 through and after the reset release; last_win returns to IF.
- Stats (RAM_ARB_STATS_EN):
  - Stimulus: 3 conflict cycles, then stat_clr.
  - Response: stat_conflicts = 3 before the clear, 0 after; counters saturate at 16'hFFFF under a forced long run.
